gcd_unit: RTL and testbench

Parametrised, handshaked greatest-common-divisor engine built on the binary (Stein) algorithm, one reduction step per clock. It is the next-generation replacement for the fixed 32-bit subtract-loop GCD datapath in the HLS sample library. It adds a generic operand width, valid/ready flow control on both sides, zero-operand handling, a coprime flag, an iteration counter and a synchronous abort. It sits between an operand producer and a result consumer in generated accelerator datapaths.

---
 rtl/gcd_unit.sv | 168 ++++++++++++++++
 tb/tb_gcd_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_unit.sv
// gcd_unit: handshaked binary (Stein) GCD engine, one reduction step per clock.
// Common factors of two are stripped first (counted in k), the odd parts are
// reduced by halving / halved differences, and the result is re-scaled by 2^k.
// Results are held in output registers until the consumer takes them.
module gcd_unit #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_gcd,
  output logic              out_coprime,
  output logic              out_zero,
  output logic [ITER_W-1:0] out_iter
);

  localparam int K_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STRIP  = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [WIDTH-1:0]    r_a, r_b, w_a_next, w_b_next;
  logic [K_W-1:0]      r_k, w_k_next;
  logic [ITER_W-1:0]   r_iter, w_iter_next, w_iter_inc;
  logic [WIDTH-1:0]    r_gcd, w_gcd_next;
  logic                r_coprime, w_coprime_next;
  logic                r_zero, w_zero_next;
  logic [ITER_W-1:0]   r_out_iter, w_out_iter_next;

  logic                w_a_gt_b;
  logic [WIDTH-1:0]    w_diff;
  logic [WIDTH-1:0]    w_in_or;
  logic [WIDTH-1:0]    w_scaled;

  // Shared datapath terms: larger-minus-smaller difference, saturating
  // iteration increment, zero-case result and the final re-scaled gcd.
  assign w_a_gt_b   = (r_a > r_b);
  assign w_diff     = w_a_gt_b ? (r_a - r_b) : (r_b - r_a);
  assign w_iter_inc = (&r_iter) ? r_iter : (r_iter + ITER_W'(1));
  assign w_in_or    = in_a | in_b;
  assign w_scaled   = r_a << r_k;

  // Next-state and next-datapath decode; every register holds by default.
  always_comb begin
    w_state_next    = r_state;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_k_next        = r_k;
    w_iter_next     = r_iter;
    w_gcd_next      = r_gcd;
    w_coprime_next  = r_coprime;
    w_zero_next     = r_zero;
    w_out_iter_next = r_out_iter;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_a_next    = in_a;
          w_b_next    = in_b;
          w_k_next    = '0;
          w_iter_next = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x,0) = x; no iterations are spent.
            w_gcd_next      = w_in_or;
            w_zero_next     = (w_in_or == '0);
            w_coprime_next  = (w_in_or == WIDTH'(1));
            w_out_iter_next = '0;
            w_state_next    = ST_DONE;
          end else begin
            w_state_next = ST_STRIP;
          end
        end
      end

      ST_STRIP: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_iter_next = w_iter_inc;
          if (!r_a[0] && !r_b[0]) begin
            w_a_next = r_a >> 1;
            w_b_next = r_b >> 1;
            w_k_next = r_k + K_W'(1);
          end else begin
            w_state_next = ST_REDUCE;
          end
        end
      end

      ST_REDUCE: begin
        if (abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_iter_next = w_iter_inc;
          if (!r_a[0]) begin
            w_a_next = r_a >> 1;
          end else if (!r_b[0]) begin
            w_b_next = r_b >> 1;
          end else if (r_a == r_b) begin
            w_gcd_next      = w_scaled;
            w_coprime_next  = (w_scaled == WIDTH'(1));
            w_zero_next     = 1'b0;
            w_out_iter_next = w_iter_inc;
            w_state_next    = ST_DONE;
          end else if (w_a_gt_b) begin
            w_a_next = w_diff >> 1;
          end else begin
            w_b_next = w_diff >> 1;
          end
        end
      end

      ST_DONE: begin
        // Abort is deliberately not looked at: a finished result is kept.
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, datapath and result registers with asynchronous clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_k        <= '0;
      r_iter     <= '0;
      r_gcd      <= '0;
      r_coprime  <= 1'b0;
      r_zero     <= 1'b0;
      r_out_iter <= '0;
    end else begin
      r_state    <= w_state_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_k        <= w_k_next;
      r_iter     <= w_iter_next;
      r_gcd      <= w_gcd_next;
      r_coprime  <= w_coprime_next;
      r_zero     <= w_zero_next;
      r_out_iter <= w_out_iter_next;
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_gcd     = r_gcd;
  assign out_coprime = r_coprime;
  assign out_zero    = r_zero;
  assign out_iter    = r_out_iter;

endmodule

// File: tb/tb_gcd_unit.sv
// tb_gcd_unit: scoreboard bench for gcd_unit at WIDTH=32 (directed + random)
// and WIDTH=8 (random), with a Euclid reference model.
module tb_gcd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        rst_n, in_valid, in_ready, abort, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_gcd;
  logic        out_coprime, out_zero;
  logic [15:0] out_iter;
  logic        rdy_dir, rdy_rnd, rnd_mode;

  // 8-bit instance signals
  logic        rst8_n, in_valid8, in_ready8, abort8, out_valid8;
  logic        out_ready8 = 1'b0;
  logic [7:0]  in_a8, in_b8, out_gcd8;
  logic        out_coprime8, out_zero8;
  logic [15:0] out_iter8;
  bit          done8 = 1'b0;

  assign out_ready = rnd_mode ? rdy_rnd : rdy_dir;

  gcd_unit #(.WIDTH(32), .ITER_W(16)) u_dut32 (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_coprime(out_coprime), .out_zero(out_zero), .out_iter(out_iter)
  );

  gcd_unit #(.WIDTH(8), .ITER_W(16)) u_dut8 (
    .sys_clk(clk), .sys_rst_n(rst8_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .abort(abort8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_gcd(out_gcd8),
    .out_coprime(out_coprime8), .out_zero(out_zero8), .out_iter(out_iter8)
  );

  typedef struct {
    logic [31:0] gcd;
    logic        cop;
    logic        zero;
    logic [15:0] iter;
    bit          chk_iter;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];
  exp_t m32, m8;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.gcd      = ref_gcd(a, b);
    e.cop      = (e.gcd == 32'd1);
    e.zero     = (a == 0) && (b == 0);
    e.iter     = '0;
    e.chk_iter = 1'b0;
    return e;
  endfunction

  // Random consumer stalls for both instances.
  always @(posedge clk) begin
    #1;
    rdy_rnd    = ($urandom_range(0, 3) != 0);
    out_ready8 = ($urandom_range(0, 3) != 0);
  end

  // 32-bit result monitor: pops the scoreboard on each completed handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb32.size() == 0) begin
        check_eq("sb32_unexpected_result", 64'(sb32.size()), 64'd1);
      end else begin
        m32 = sb32.pop_front();
        $display("txn32 gcd=0x%0h cop=%0d zero=%0d iter=%0d", out_gcd, out_coprime, out_zero, out_iter);
        check_eq("gcd32", out_gcd, m32.gcd);
        check_eq("coprime32", out_coprime, m32.cop);
        check_eq("zero32", out_zero, m32.zero);
        if (m32.chk_iter) check_eq("iter32", out_iter, m32.iter);
        else              check_eq("iter32_bound", 64'(out_iter <= 16'd98), 64'd1);
      end
    end
  end

  // 8-bit result monitor.
  always @(negedge clk) begin
    if (rst8_n && out_valid8 && out_ready8) begin
      if (sb8.size() == 0) begin
        check_eq("sb8_unexpected_result", 64'(sb8.size()), 64'd1);
      end else begin
        m8 = sb8.pop_front();
        $display("txn8 gcd=0x%0h cop=%0d zero=%0d iter=%0d", out_gcd8, out_coprime8, out_zero8, out_iter8);
        check_eq("gcd8", out_gcd8, m8.gcd);
        check_eq("coprime8", out_coprime8, m8.cop);
        check_eq("zero8", out_zero8, m8.zero);
        check_eq("iter8_bound", 64'(out_iter8 <= 16'd26), 64'd1);
      end
    end
  end

  // Offer a pair and return #1 after the accepting edge. Called #1 after a posedge.
  task automatic send32(input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send32_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok        = 1'b0;
    in_a8     = a;
    in_b8     = b;
    in_valid8 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("send8_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  // Directed job with out_ready held high: checks result fields and latency.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eg,
                       input logic ec, input logic ez, input logic [15:0] ei);
    exp_t e;
    int   cnt;
    bit   seen;
    e.gcd = eg; e.cop = ec; e.zero = ez; e.iter = ei; e.chk_iter = 1'b1;
    sb32.push_back(e);
    send32(a, b);
    seen = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cnt++;
    end
    check_eq("latency32_seen", 64'(seen), 64'd1);
    check_eq("latency32", 64'(cnt), 64'(ei));
    @(posedge clk);
    #1;
  endtask

  // WIDTH=8 random stream with random stalls.
  initial begin
    logic [7:0] a, b;
    rst8_n    = 1'b0;
    in_valid8 = 1'b0;
    in_a8     = '0;
    in_b8     = '0;
    abort8    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      sb8.push_back(mk_exp({24'd0, a}, {24'd0, b}));
      send8(a, b);
    end
    for (int i = 0; i < 2000 && sb8.size() != 0; i++) @(posedge clk);
    check_eq("drain8", 64'(sb8.size()), 64'd0);
    done8 = 1'b1;
  end

  // WIDTH=32 directed tests followed by a random stream.
  initial begin
    logic [31:0] a, b, g;
    int          s;
    bit          seen;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    abort    = 1'b0;
    rdy_dir  = 1'b1;
    rnd_mode = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1'b1);
    check_eq("post_rst_out_valid", out_valid, 1'b0);
    check_eq("post_rst_gcd", out_gcd, 32'd0);
    check_eq("post_rst_coprime", out_coprime, 1'b0);
    check_eq("post_rst_zero", out_zero, 1'b0);
    check_eq("post_rst_iter", out_iter, 16'd0);
    @(posedge clk);
    #1;

    run32(32'd12, 32'd18, 32'd6, 1'b0, 1'b0, 16'd5);
    run32(32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 16'd33);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 16'd2);
    run32(32'd1, 32'd1, 32'd1, 1'b1, 1'b0, 16'd2);
    run32(32'd0, 32'd7, 32'd7, 1'b0, 1'b0, 16'd0);
    run32(32'd0, 32'd0, 32'd0, 1'b0, 1'b1, 16'd0);
    run32(32'd0, 32'd1, 32'd1, 1'b1, 1'b0, 16'd0);

    // Backpressure: result for 35,64 held while a new pair is offered.
    rdy_dir = 1'b0;
    begin
      exp_t e;
      e.gcd = 32'd1; e.cop = 1'b1; e.zero = 1'b0; e.iter = 16'd13; e.chk_iter = 1'b1;
      sb32.push_back(e);
    end
    send32(32'd35, 32'd64);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("bp_out_valid_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_a     = 32'd5;
      in_b     = 32'd10;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_gcd", out_gcd, 32'd1);
      check_eq("bp_coprime", out_coprime, 1'b1);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rdy_dir  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("hs_in_ready", in_ready, 1'b1);
    check_eq("hs_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Abort in REDUCE: accepted at E, STRIP at E+1, REDUCE after E+2.
    send32(32'd12, 32'd18);
    @(posedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    run32(32'd21, 32'd14, 32'd7, 1'b0, 1'b0, 16'd4);

    // Asynchronous reset while in STRIP.
    send32(32'd12, 32'd18);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    check_eq("arst_gcd", out_gcd, 32'd0);
    check_eq("arst_iter", out_iter, 16'd0);
    check_eq("arst_coprime", out_coprime, 1'b0);
    check_eq("arst_zero", out_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_rel_in_ready", in_ready, 1'b1);
    check_eq("arst_rel_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Random stream with stalls.
    rnd_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin
          g = $urandom_range(1, 5000);
          a = g * $urandom_range(0, 50000);
          b = g * $urandom_range(0, 50000);
        end
        2: begin
          s = $urandom_range(0, 20);
          a = $urandom << s;
          b = $urandom << s;
        end
        default: begin a = 32'd0; b = $urandom_range(0, 3); end
      endcase
      sb32.push_back(mk_exp(a, b));
      send32(a, b);
    end
    for (int i = 0; i < 3000 && sb32.size() != 0; i++) @(posedge clk);
    check_eq("drain32", 64'(sb32.size()), 64'd0);

    for (int i = 0; i < 60000 && !done8; i++) @(posedge clk);
    check_eq("done8", 64'(done8), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
